// File: rtl/mux4_rr_sched.sv
// Round-robin owner of a shared 4:1 data mux. It grants one source at a time with a bounded hold.
// It also registers the selected word as y.
module mux4_rr_sched #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic [DATA_W-1:0] d3,
   output logic [3:0]        gnt,
   output logic [1:0]        sel,
   output logic [DATA_W-1:0] y,
   output logic              y_valid,
   output logic              busy
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic {IDLE, OWN} state_t;

   state_t              state_q, state_d;
   logic [3:0]          gnt_q, gnt_d;
   logic [1:0]          sel_q, sel_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [DATA_W-1:0]   y_q;
   logic                y_valid_q;

   logic [1:0]          win;
   logic                own_req;
   logic                others;
   logic [DATA_W-1:0]   mux_out;

   // First set request bit found when searching from ptr upward (mod 4).
   always_comb begin
      logic       found;
      logic [1:0] idx;
      found = 1'b0;
      win   = 2'd0;
      idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign own_req = req[sel_q];
   assign others  = |(req & ~gnt_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = OWN;
               gnt_d   = 4'b0001 << win;
               sel_d   = win;
               ptr_d   = win + 2'd1;
               hold_d  = HW'(1);
            end
         end
         OWN: begin
            // Preemption relies on ptr already pointing past the owner, so the owner loses ties.
            if ((!own_req && others) || (own_req && hold_q == HOLD_MAX && others)) begin
               gnt_d  = 4'b0001 << win;
               sel_d  = win;
               ptr_d  = win + 2'd1;
               hold_d = HW'(1);
            end else if (!own_req) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      unique case (sel_q)
         2'd0:    mux_out = d0;
         2'd1:    mux_out = d1;
         2'd2:    mux_out = d2;
         default: mux_out = d3;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         sel_q     <= 2'd0;
         ptr_q     <= 2'd0;
         hold_q    <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         if (state_q == OWN && own_req) begin
            y_q       <= mux_out;
            y_valid_q <= 1'b1;
         end else begin
            y_valid_q <= 1'b0;
         end
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign busy    = (state_q == OWN);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: reset, single owner, full rotation, release, lone hold,
// and async reset mid-grant.
module tb_mux4_rr_sched;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [7:0] d0, d1, d2, d3;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic [7:0] y;
   logic       y_valid;
   logic       busy;

   int total;
   int bad;
   logic [7:0] dat [4];

   mux4_rr_sched #(.DATA_W(8), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".gnt"},  32'(gnt), 32'h0);
      chk({tag, ".sel"},  32'(sel), 32'h0);
      chk({tag, ".y"},    32'(y), 32'h0);
      chk({tag, ".yv"},   32'(y_valid), 32'h0);
      chk({tag, ".busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      req   = 4'b0000;
      d0 = 8'hA1; d1 = 8'hB2; d2 = 8'hC3; d3 = 8'hD4;
      dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3; dat[3] = 8'hD4;

      // 1: reset, then idle with no requests
      repeat (3) @(posedge clk);
      #1;
      chk_idle("t1.rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_idle("t1.idle1");
      tick();
      chk_idle("t1.idle2");

      // 2: single requester for 3 cycles
      @(negedge clk);
      req = 4'b0001;
      tick();
      chk("t2.e1.gnt", 32'(gnt), 32'h1);
      chk("t2.e1.busy", 32'(busy), 32'h1);
      chk("t2.e1.yv", 32'(y_valid), 32'h0);
      tick();
      chk("t2.e2.y", 32'(y), 32'hA1);
      chk("t2.e2.yv", 32'(y_valid), 32'h1);
      tick();
      chk("t2.e3.y", 32'(y), 32'hA1);
      chk("t2.e3.yv", 32'(y_valid), 32'h1);
      @(negedge clk);
      req = 4'b0000;
      tick();
      chk("t2.e4.gnt", 32'(gnt), 32'h0);
      chk("t2.e4.busy", 32'(busy), 32'h0);
      chk("t2.e4.yv", 32'(y_valid), 32'h0);
      chk("t2.e4.y", 32'(y), 32'hA1);
      chk("t2.e4.sel", 32'(sel), 32'h0);

      // 3: all four requesting, four cycles each in order 0,1,2,3,0
      do_reset();
      @(negedge clk);
      req = 4'b1111;
      for (int n = 1; n <= 20; n++) begin
         int own;
         own = ((n - 1) / 4) % 4;
         tick();
         chk($sformatf("t3.e%0d.gnt", n), 32'(gnt), 32'(4'b0001 << own));
         chk($sformatf("t3.e%0d.sel", n), 32'(sel), 32'(own));
         if (n >= 2) begin
            chk($sformatf("t3.e%0d.y", n), 32'(y), 32'(dat[((n - 2) / 4) % 4]));
            chk($sformatf("t3.e%0d.yv", n), 32'(y_valid), 32'h1);
         end
      end

      // 4: owner 1 releases while 0 and 2 wait; ptr=2 so source 2 wins
      do_reset();
      @(negedge clk);
      req = 4'b0010;
      tick();
      chk("t4.own1.gnt", 32'(gnt), 32'h2);
      @(negedge clk);
      req = 4'b0111;
      tick();
      chk("t4.hold.gnt", 32'(gnt), 32'h2);
      @(negedge clk);
      req = 4'b0101;
      tick();
      chk("t4.rel.gnt", 32'(gnt), 32'h4);
      chk("t4.rel.sel", 32'(sel), 32'h2);
      chk("t4.rel.busy", 32'(busy), 32'h1);
      tick();
      chk("t4.rel.y", 32'(y), 32'hC3);
      chk("t4.rel.yv", 32'(y_valid), 32'h1);

      // 5: lone requester holds past MAX_HOLD, then loses to source 0 immediately
      do_reset();
      @(negedge clk);
      req = 4'b0100;
      for (int n = 1; n <= 10; n++) begin
         tick();
         chk($sformatf("t5.e%0d.gnt", n), 32'(gnt), 32'h4);
         if (n >= 2) chk($sformatf("t5.e%0d.y", n), 32'({y_valid, y}), 32'h1C3);
      end
      @(negedge clk);
      req = 4'b0101;
      tick();
      chk("t5.pre.gnt", 32'(gnt), 32'h1);
      chk("t5.pre.sel", 32'(sel), 32'h0);
      tick();
      chk("t5.pre.y", 32'(y), 32'hA1);

      // 6: async reset mid-grant, then ptr back at 0
      do_reset();
      @(negedge clk);
      req = 4'b0010;
      tick();
      chk("t6.gnt", 32'(gnt), 32'h2);
      tick();
      chk("t6.y", 32'({y_valid, y}), 32'h1B2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("t6.async");
      @(negedge clk);
      req   = 4'b1001;
      rst_n = 1'b1;
      tick();
      chk("t6.after.gnt", 32'(gnt), 32'h1);
      chk("t6.after.sel", 32'(sel), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
